// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants, types and helpers for the synchronous FIFO.
//   DEF_DATA_W / DEF_DEPTH : default word width and entry count
//   addr_w()               : pointer width for a given depth
//   op_e                   : accepted-operation encoding {write, read}
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;

  // Pointer width; count is one bit wider so it can represent DEPTH itself.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Bit order matches the concatenation {wr_ok, rd_ok}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

endpackage : fifo_pkg

// File: rtl/fifo_if.sv
// -----------------------------------------------------------------------------
// fifo_if
// Producer/consumer bundle for the FIFO.
//   wr_en, wr_data        : push request and word (master -> slave)
//   rd_en                 : pop request           (master -> slave)
//   rd_data, rd_valid     : registered pop result (slave -> master)
//   count                 : occupancy 0..DEPTH
//   full, empty           : boundary flags
//   almost_full/_empty    : threshold flags
//   overflow, underflow   : sticky rejection flags
// The master modport is the user side, the slave modport is the FIFO.
// -----------------------------------------------------------------------------
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  logic                       wr_en;
  logic [DATA_W-1:0]          wr_data;
  logic                       rd_en;
  logic [DATA_W-1:0]          rd_data;
  logic                       rd_valid;
  logic [addr_w(DEPTH):0]     count;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, rd_valid, count, full, empty,
           almost_full, almost_empty, overflow, underflow
  );

endinterface : fifo_if

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage array: synchronous write, synchronous registered
// read. rdata holds its value on cycles without re.
//   clock : rising-edge clock
//   we    : write enable, waddr/wdata written at the edge
//   re    : read enable, mem[raddr] captured into rdata at the edge
// A read and write to the same address in one cycle returns the old word.
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM; stale words are never
  // observable because the pointers and count are reset instead.
  // NOTE: non-blocking assignments here give read-old-data on a same-address
  // collision and keep the ordering between flops race-free.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule : fifo_mem

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Single-clock first-in-first-out buffer with registered read port,
// occupancy count, almost-full/almost-empty thresholds and sticky errors.
//   clock : rising-edge clock
//   reset : synchronous, active-high; overrides wr_en/rd_en
//   bus   : fifo_if.slave (handshake, data, count, flags, errors)
// A full FIFO accepts a simultaneous read and write; an empty FIFO accepts
// only the write of such a pair (reads never bypass the memory).
// -----------------------------------------------------------------------------
module fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic   clock,
  input  logic   reset,
  fifo_if.slave  bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo: DEPTH must be a power of two and at least 2");
  end
  if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
    $error("fifo: thresholds must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_seen_q, rd_seen_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              full, empty;
  logic              wr_ok, rd_ok;
  op_e               op;
  logic [DATA_W-1:0] mem_rdata;

  // Flags decode registered count only, so they never follow the inputs.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  assign wr_ok = bus.wr_en & (~full | bus.rd_en);
  assign rd_ok = bus.rd_en & ~empty;
  assign op    = op_e'({wr_ok, rd_ok});

  // NOTE: every always_comb output gets its default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = 1'b0;
    rd_seen_d   = rd_seen_q;
    overflow_d  = overflow_q  | (bus.wr_en & ~wr_ok);
    underflow_d = underflow_q | (bus.rd_en & ~rd_ok);

    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_ok) begin
      rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
      rd_valid_d = 1'b1;
      rd_seen_d  = 1'b1;
    end

    unique case (op)
      OP_PUSH: count_d = count_q + CNT_W'(1);
      OP_POP:  count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_seen_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      rd_seen_q   <= rd_seen_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Enables are gated by reset so a reset cycle leaves the array untouched.
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock (clock),
    .we    (wr_ok & ~reset),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .re    (rd_ok & ~reset),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

  // The array's read register cannot be reset, so rd_data shows zero until
  // the first pop after reset; rd_seen_q is a flop, so this stays glitch-free.
  assign bus.rd_data      = rd_seen_q ? mem_rdata : '0;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule : fifo
